mem_wb_skid: RTL

Parametrised MEM/WB pipeline stage: registers the GPR write-back and HI/LO write-back payloads from MEM to WB with a valid/ready handshake. It carries a two-entry skid buffer so back-pressure does not combinationally reach the MEM stage. It supports a flush, which kills in-flight writes on exception or redirect. It replaces the plain always-accepting MEM/WB register and reuses the widths in `define.v`.

---
 rtl/mem_wb_skid_pkg.sv | 22 ++
 rtl/mem_wb_skid_if.sv | 48 ++++
 rtl/mem_wb_skid_skid_buf.sv | 90 +++++++++
 rtl/mem_wb_skid.sv | 64 ++++++
 4 files changed

// File: rtl/mem_wb_skid_pkg.sv
// Shared constants and helpers for the MEM/WB skid stage.
// The payload width depends on the MEM_WB_HILO_EN build macro.
package mem_wb_skid_pkg;

    localparam int          REG_BUS_W     = 32;
    localparam int          REG_ADDR_W    = 5;
    localparam logic        RST_ENABLE    = 1'b1;
    localparam logic        WRITE_ENABLE  = 1'b1;
    localparam logic        WRITE_DISABLE = 1'b0;
    localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
    localparam logic [4:0]  NOP_REG_ADDR  = 5'b00000;

    // Layout, LSB first: wdata, wreg, wd [, whilo, lo, hi]
    function automatic int payload_w(input int data_w, input int addr_w);
`ifdef MEM_WB_HILO_EN
        return data_w + 1 + addr_w + 1 + 2 * data_w;
`else
        return data_w + 1 + addr_w;
`endif
    endfunction

endpackage

// File: rtl/mem_wb_skid_if.sv
// MEM->WB handshake bundle. HI/LO signals exist only when
// MEM_WB_HILO_EN is defined.
interface mem_wb_skid_if
    import mem_wb_skid_pkg::*;
#(
    parameter int DATA_W = REG_BUS_W,
    parameter int ADDR_W = REG_ADDR_W
) ();

    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_wd;
    logic              mem_wreg;
    logic [DATA_W-1:0] mem_wdata;
    logic              wb_valid;
    logic              wb_ready;
    logic [ADDR_W-1:0] wb_wd;
    logic              wb_wreg;
    logic [DATA_W-1:0] wb_wdata;
`ifdef MEM_WB_HILO_EN
    logic [DATA_W-1:0] mem_hi;
    logic [DATA_W-1:0] mem_lo;
    logic              mem_whilo;
    logic [DATA_W-1:0] wb_hi;
    logic [DATA_W-1:0] wb_lo;
    logic              wb_whilo;
`endif

    // master: the MEM/WB environment; slave: the pipeline stage itself
    modport master (
        output mem_valid, mem_wd, mem_wreg, mem_wdata, wb_ready,
`ifdef MEM_WB_HILO_EN
        output mem_hi, mem_lo, mem_whilo,
        input  wb_hi, wb_lo, wb_whilo,
`endif
        input  mem_ready, wb_valid, wb_wd, wb_wreg, wb_wdata
    );

    modport slave (
        input  mem_valid, mem_wd, mem_wreg, mem_wdata, wb_ready,
`ifdef MEM_WB_HILO_EN
        input  mem_hi, mem_lo, mem_whilo,
        output wb_hi, wb_lo, wb_whilo,
`endif
        output mem_ready, wb_valid, wb_wd, wb_wreg, wb_wdata
    );

endinterface

// File: rtl/mem_wb_skid_skid_buf.sv
// Generic two-entry valid/ready skid buffer over a packed payload.
// Ready is registered, so o_ready never depends on i_out_ready combinationally.
module skid_buf #(
    parameter int             W       = 8,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         i_flush,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_out_ready,
    output logic [W-1:0] o_data
);

    logic         r_main_valid;
    logic         r_skid_valid;
    logic         r_ready;
    logic [W-1:0] r_main_data;
    logic [W-1:0] r_skid_data;

    logic w_accept;
    logic w_consume;
    logic w_main_valid_next;
    logic w_skid_valid_next;
    logic w_main_from_in;
    logic w_main_from_skid;
    logic w_skid_from_in;

    always_comb begin
        w_accept          = i_valid & r_ready;
        w_consume         = r_main_valid & i_out_ready;
        w_main_valid_next = r_main_valid;
        w_skid_valid_next = r_skid_valid;
        w_main_from_in    = 1'b0;
        w_main_from_skid  = 1'b0;
        w_skid_from_in    = 1'b0;
        if (i_flush) begin
            w_main_valid_next = 1'b0;
            w_skid_valid_next = 1'b0;
        end else if (w_consume) begin
            // r_ready is low while skid is full, so accept and skid never coincide here
            if (r_skid_valid) begin
                w_main_from_skid  = 1'b1;
                w_skid_valid_next = 1'b0;
            end else if (w_accept) begin
                w_main_from_in    = 1'b1;
            end else begin
                w_main_valid_next = 1'b0;
            end
        end else if (w_accept) begin
            if (!r_main_valid) begin
                w_main_from_in    = 1'b1;
                w_main_valid_next = 1'b1;
            end else begin
                w_skid_from_in    = 1'b1;
                w_skid_valid_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_ready      <= 1'b1;
            r_main_data  <= RST_VAL;
            r_skid_data  <= RST_VAL;
        end else begin
            r_main_valid <= w_main_valid_next;
            r_skid_valid <= w_skid_valid_next;
            r_ready      <= !w_skid_valid_next;
            if (w_main_from_in) begin
                r_main_data <= i_data;
            end else if (w_main_from_skid) begin
                r_main_data <= r_skid_data;
            end
            if (w_skid_from_in) begin
                r_skid_data <= i_data;
            end
        end
    end

    assign o_ready = r_ready;
    assign o_valid = r_main_valid;
    assign o_data  = r_main_data;

endmodule

// File: rtl/mem_wb_skid.sv
// MEM/WB pipeline stage with a two-entry skid buffer and flush.
// HI/LO write-back is carried only when MEM_WB_HILO_EN is defined.
module mem_wb_skid
    import mem_wb_skid_pkg::*;
#(
    parameter int DATA_W = REG_BUS_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    mem_wb_skid_if.slave  bus
);

    localparam int PW = payload_w(DATA_W, ADDR_W);

`ifdef MEM_WB_HILO_EN
    localparam logic [PW-1:0] RST_PAYLOAD = {DATA_W'(ZERO_WORD), DATA_W'(ZERO_WORD), WRITE_DISABLE,
                                             ADDR_W'(NOP_REG_ADDR), WRITE_DISABLE, DATA_W'(ZERO_WORD)};
`else
    localparam logic [PW-1:0] RST_PAYLOAD = {ADDR_W'(NOP_REG_ADDR), WRITE_DISABLE, DATA_W'(ZERO_WORD)};
`endif

    logic          w_srst;
    logic [PW-1:0] w_in_data;
    logic [PW-1:0] w_out_data;
    logic          w_out_valid;

    assign w_srst = (rst == RST_ENABLE);

`ifdef MEM_WB_HILO_EN
    assign w_in_data = {bus.mem_hi, bus.mem_lo, bus.mem_whilo,
                        bus.mem_wd, bus.mem_wreg, bus.mem_wdata};
`else
    assign w_in_data = {bus.mem_wd, bus.mem_wreg, bus.mem_wdata};
`endif

    skid_buf #(
        .W       (PW),
        .RST_VAL (RST_PAYLOAD)
    ) u_skid_buf (
        .clk         (clk),
        .srst        (w_srst),
        .i_flush     (flush),
        .i_valid     (bus.mem_valid),
        .o_ready     (bus.mem_ready),
        .i_data      (w_in_data),
        .o_valid     (w_out_valid),
        .i_out_ready (bus.wb_ready),
        .o_data      (w_out_data)
    );

    // Write enables are gated by valid so a bubble or cleared entry never writes
    assign bus.wb_valid = w_out_valid;
    assign bus.wb_wdata = w_out_data[DATA_W-1:0];
    assign bus.wb_wreg  = w_out_data[DATA_W] & w_out_valid;
    assign bus.wb_wd    = w_out_data[DATA_W+1 +: ADDR_W];
`ifdef MEM_WB_HILO_EN
    assign bus.wb_whilo = w_out_data[DATA_W+1+ADDR_W] & w_out_valid;
    assign bus.wb_lo    = w_out_data[DATA_W+2+ADDR_W +: DATA_W];
    assign bus.wb_hi    = w_out_data[2*DATA_W+2+ADDR_W +: DATA_W];
`endif

endmodule
